branch_predictor_gshare: RTL and testbench
==========================================

Name: branch_predictor_gshare

Overview:
Parametrised next-generation fetch-stage predictor; sits under the program counter and supplies new_pc every cycle.
- Direct-mapped tagged BTB, filled from decode.
- Gshare direction table of N-bit saturating counters, indexed by pc XOR global history register (GHR).
- GHR is updated speculatively at fetch and repaired from execute on mispredict.
- Conditional branches and unconditional jumps are distinguished per BTB entry.

Parameters:
WORD_SIZE, 16, address/instruction word width
IDX_BITS, 8, BTB/PHT index width; table depth = 2^IDX_BITS
GHR_BITS, 8, global history length; legal range 1..IDX_BITS
CTR_BITS, 2, direction counter width; legal range 1..4
CTR_INIT, 2^(CTR_BITS-1), counter reset value (weakest taken)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
pc  in  WORD_SIZE  current fetch PC
pc_next_seq  in  WORD_SIZE  sequential successor of pc
fetch_valid  in  1  fetch advances this cycle; enables speculative GHR shift
new_pc  out  WORD_SIZE  predicted next PC (combinational)
pred_taken  out  1  prediction used redirect (combinational)
pred_ghr  out  GHR_BITS  GHR value used for this lookup; carried down the pipe
id_update  in  1  decoded instruction is a branch/jump with a known target
id_pc  in  WORD_SIZE  PC of decoded instruction
id_target  in  WORD_SIZE  decoded target
id_is_jump  in  1  1 = unconditional jump, 0 = conditional branch
ex_valid  in  1  resolved control instruction in EX
ex_pc  in  WORD_SIZE  PC of resolved instruction
ex_is_branch  in  1  resolved instruction is a conditional branch
ex_taken  in  1  actual branch outcome
ex_ghr  in  GHR_BITS  pred_ghr captured when the instruction was fetched
ex_mispredict  in  1  EX detected a wrong next PC (direction or target)

Behaviour:
Reset (reset_n=0 at posedge clk):
- Every BTB valid bit cleared, targets 0, is_jump 0.
- Every PHT counter set to CTR_INIT; GHR set to 0.
- Reset wins over all other updates in that cycle.
- Outputs after reset: pred_taken=0, new_pc=pc_next_seq, pred_ghr=0.

Lookup (combinational):
- bidx = pc[IDX_BITS-1:0]; tag = pc[WORD_SIZE-1:IDX_BITS].
- hit = valid[bidx] && tag match.
- pidx = bidx XOR zero-extended GHR.
- pred_taken = hit && (is_jump[bidx] || PHT[pidx] MSB).
- new_pc = pred_taken ? target[bidx] : pc_next_seq.

BTB write: on id_update, the entry at id_pc's index gets tag, target, is_jump and valid=1 at the next posedge. A same-cycle lookup of the same index sees the old contents.

PHT update:
- On ex_valid && ex_is_branch, counter at ex_pc[IDX-1:0] XOR ex_ghr is updated.
- Taken: +1, saturating at all-ones. Not taken: -1, saturating at 0.
- Update is visible next cycle.
- Jumps never touch the PHT.

GHR priority, highest first:
1. Reset.
2. Repair: ex_valid && ex_mispredict && ex_is_branch gives GHR <= {ex_ghr[GHR_BITS-2:0], ex_taken}. ex_mispredict on a non-branch gives GHR <= ex_ghr.
3. Speculative: fetch_valid && hit && !is_jump[bidx] gives GHR <= {GHR[GHR_BITS-2:0], PHT[pidx] MSB}.
4. Otherwise hold.

Boundary cases:
- If GHR_BITS=1, the shift degenerates to a single bit.
- Repair in the same cycle as a fetch lookup discards the fetch shift.
- new_pc is recomputed from the repaired state the following cycle.

Optional Feature:
BP_STATS_EN:
- When defined, adds outputs stat_lookups, stat_branches and stat_mispredicts, each 32-bit and saturating.
- stat_lookups increments on fetch_valid && hit.
- stat_branches increments on ex_valid && ex_is_branch.
- stat_mispredicts increments on ex_valid && ex_mispredict.
- All three clear on reset.
- When not defined, these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
Shared package holds:
- counter helper constants: CTR_MAX = all-ones and CTR_TAKEN_BIT = CTR_BITS-1;
- a BTB entry struct {valid, is_jump, tag, target};
- the gshare index function.

One natural sub-module, bp_sat_counter_table: PHT array with read port, write port and saturating increment/decrement. The top level holds the BTB, GHR and muxing.

Test Plan:
- Reset, then pc=0x0010, pc_next_seq=0x0011 -> new_pc=0x0011, pred_taken=0, pred_ghr=0.
- id_update, id_pc=0x0010, id_target=0x0040, id_is_jump=1; next cycle pc=0x0010 -> new_pc=0x0040, pred_taken=1; GHR unchanged with fetch_valid=1.
- Conditional branch at 0x0020 → 0x0005 installed, CTR_INIT=2. Lookup with fetch_valid predicts taken, and GHR shifts 0x00→0x01. Two not-taken EX resolutions at ex_ghr=0 take that counter 2→1→0, so a later lookup with GHR=0 gives new_pc=pc_next_seq.
- GHR=0x0B speculative, then ex_mispredict=1, ex_is_branch=1, ex_ghr=0x05, ex_taken=0 with fetch_valid=1 the same cycle -> GHR=0x0A next cycle (repair wins).
- Alias: pc 0x0110 (tag differs from installed 0x0010) -> hit=0, new_pc=pc_next_seq.
- BP_STATS_EN: 3 hits, 2 branch resolutions, 1 mispredict -> counters 3/2/1; reset mid-run -> all 0.

Source files
------------

// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types and helpers for the gshare predictor: BTB entry layout,
// saturating-counter constants and the gshare index hash.
package branch_predictor_gshare_pkg;

  // Widest address supported; narrower builds cast into and out of it.
  localparam int ADDR_MAX = 32;

  typedef logic [ADDR_MAX-1:0] addr_t;

  typedef struct packed {
    logic  valid;
    logic  is_jump;
    addr_t tag;
    addr_t target;
  } btb_entry_t;

  function automatic int ctr_max(input int ctr_bits);
    return (1 << ctr_bits) - 1;
  endfunction

  function automatic int ctr_taken_bit(input int ctr_bits);
    return ctr_bits - 1;
  endfunction

  function automatic int ctr_init(input int ctr_bits);
    return 1 << (ctr_bits - 1);
  endfunction

  function automatic addr_t gshare_index(input addr_t bidx, input addr_t ghr);
    return bidx ^ ghr;
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Fetch/decode/execute signal bundle between the pipeline (master) and the
// predictor (slave).
interface branch_predictor_gshare_if #(
  parameter int WORD_SIZE = 16,
  parameter int GHR_BITS  = 8
);
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pc_next_seq;
  logic                 fetch_valid;
  logic [WORD_SIZE-1:0] new_pc;
  logic                 pred_taken;
  logic [GHR_BITS-1:0]  pred_ghr;
  logic                 id_update;
  logic [WORD_SIZE-1:0] id_pc;
  logic [WORD_SIZE-1:0] id_target;
  logic                 id_is_jump;
  logic                 ex_valid;
  logic [WORD_SIZE-1:0] ex_pc;
  logic                 ex_is_branch;
  logic                 ex_taken;
  logic [GHR_BITS-1:0]  ex_ghr;
  logic                 ex_mispredict;

  modport master (
    output pc, pc_next_seq, fetch_valid,
    output id_update, id_pc, id_target, id_is_jump,
    output ex_valid, ex_pc, ex_is_branch, ex_taken, ex_ghr, ex_mispredict,
    input  new_pc, pred_taken, pred_ghr
  );

  modport slave (
    input  pc, pc_next_seq, fetch_valid,
    input  id_update, id_pc, id_target, id_is_jump,
    input  ex_valid, ex_pc, ex_is_branch, ex_taken, ex_ghr, ex_mispredict,
    output new_pc, pred_taken, pred_ghr
  );
endinterface

// File: rtl/branch_predictor_gshare_sat_counter_table.sv
// Pattern history table: array of saturating direction counters with an
// asynchronous read of the taken bit and one increment/decrement write port.
module bp_sat_counter_table
  import branch_predictor_gshare_pkg::*;
#(
  parameter int IDX_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic                o_rd_taken,
  input  logic                i_wr_en,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic                i_wr_inc
);
  localparam int                DEPTH         = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX     = CTR_BITS'(ctr_max(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_INIT    = CTR_BITS'(ctr_init(CTR_BITS));
  localparam int                CTR_TAKEN_BIT = ctr_taken_bit(CTR_BITS);

  logic [CTR_BITS-1:0] r_ctr [DEPTH];
  logic [CTR_BITS-1:0] w_wr_old;

  assign o_rd_taken = r_ctr[i_rd_idx][CTR_TAKEN_BIT];
  assign w_wr_old   = r_ctr[i_wr_idx];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= CTR_INIT;
      end
    end else if (i_wr_en) begin
      if (i_wr_inc && (w_wr_old != CTR_MAX)) begin
        r_ctr[i_wr_idx] <= w_wr_old + 1'b1;
      end else if (!i_wr_inc && (w_wr_old != '0)) begin
        r_ctr[i_wr_idx] <= w_wr_old - 1'b1;
      end
    end
  end
endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare fetch predictor: tagged direct-mapped BTB, speculative GHR with
// execute-stage repair. Define BP_STATS_EN to add saturating event counters.
module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 8,
  parameter int GHR_BITS  = 8,
  parameter int CTR_BITS  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef BP_STATS_EN
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  branch_predictor_gshare_if.slave bp
);
  localparam int DEPTH = 1 << IDX_BITS;

  btb_entry_t          r_btb [DEPTH];
  logic [GHR_BITS-1:0] r_ghr;

  btb_entry_t          w_entry;
  btb_entry_t          w_id_entry;
  logic [IDX_BITS-1:0] w_bidx;
  logic [IDX_BITS-1:0] w_pidx;
  logic [IDX_BITS-1:0] w_id_idx;
  logic [IDX_BITS-1:0] w_ex_pidx;
  logic                w_hit;
  logic                w_pht_taken;
  logic                w_spec_shift;
  logic                w_repair;
  logic                w_pht_wr;

  assign w_bidx    = bp.pc[IDX_BITS-1:0];
  assign w_entry   = r_btb[w_bidx];
  assign w_hit     = w_entry.valid && (w_entry.tag == addr_t'(bp.pc[WORD_SIZE-1:IDX_BITS]));
  assign w_pidx    = IDX_BITS'(gshare_index(addr_t'(w_bidx), addr_t'(r_ghr)));
  assign w_ex_pidx = IDX_BITS'(gshare_index(addr_t'(bp.ex_pc), addr_t'(bp.ex_ghr)));
  assign w_id_idx  = bp.id_pc[IDX_BITS-1:0];

  assign w_id_entry = '{valid:   1'b1,
                        is_jump: bp.id_is_jump,
                        tag:     addr_t'(bp.id_pc[WORD_SIZE-1:IDX_BITS]),
                        target:  addr_t'(bp.id_target)};

  assign bp.pred_taken = w_hit && (w_entry.is_jump || w_pht_taken);
  assign bp.new_pc     = bp.pred_taken ? WORD_SIZE'(w_entry.target) : bp.pc_next_seq;
  assign bp.pred_ghr   = r_ghr;

  assign w_pht_wr     = bp.ex_valid && bp.ex_is_branch;
  assign w_repair     = bp.ex_valid && bp.ex_mispredict;
  assign w_spec_shift = bp.fetch_valid && w_hit && !w_entry.is_jump;

  bp_sat_counter_table #(
    .IDX_BITS (IDX_BITS),
    .CTR_BITS (CTR_BITS)
  ) u_pht (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_rd_idx   (w_pidx),
    .o_rd_taken (w_pht_taken),
    .i_wr_en    (w_pht_wr),
    .i_wr_idx   (w_ex_pidx),
    .i_wr_inc   (bp.ex_taken)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_btb[i] <= '0;
      end
    end else if (bp.id_update) begin
      r_btb[w_id_idx] <= w_id_entry;
    end
  end

  // Casting {history, bit} down to GHR_BITS drops the oldest bit, which also
  // covers the single-bit history case.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ghr <= '0;
    end else if (w_repair) begin
      r_ghr <= bp.ex_is_branch ? GHR_BITS'({bp.ex_ghr, bp.ex_taken}) : bp.ex_ghr;
    end else if (w_spec_shift) begin
      r_ghr <= GHR_BITS'({r_ghr, w_pht_taken});
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_lookups     <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (bp.fetch_valid && w_hit && (stat_lookups != '1)) begin
        stat_lookups <= stat_lookups + 32'd1;
      end
      if (w_pht_wr && (stat_branches != '1)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (w_repair && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Randomised bench for branch_predictor_gshare against an array-based
// reference model, plus directed scenarios with literal expectations.
module tb_branch_predictor_gshare;
  localparam int WS = 16;
  localparam int IB = 8;
  localparam int GB = 8;
  localparam int CB = 2;
  localparam int NENT = 1 << IB;
  localparam int CINIT = 1 << (CB - 1);
  localparam int CMAX = (1 << CB) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_gshare_if #(.WORD_SIZE(WS), .GHR_BITS(GB)) bp ();

`ifdef BP_STATS_EN
  logic [31:0] stat_lookups, stat_branches, stat_mispredicts;
`endif

  branch_predictor_gshare #(
    .WORD_SIZE(WS), .IDX_BITS(IB), .GHR_BITS(GB), .CTR_BITS(CB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef BP_STATS_EN
    .stat_lookups(stat_lookups),
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts),
`endif
    .bp(bp)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: plain arrays indexed by table slot.
  bit m_v [NENT];
  bit m_j [NENT];
  int m_tag [NENT];
  int m_tgt [NENT];
  int m_pht [NENT];
  int m_ghr;
  int m_st_look, m_st_br, m_st_mis;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic set_idle();
    bp.fetch_valid = 1'b0;
    bp.id_update = 1'b0;
    bp.id_pc = '0;
    bp.id_target = '0;
    bp.id_is_jump = 1'b0;
    bp.ex_valid = 1'b0;
    bp.ex_pc = '0;
    bp.ex_is_branch = 1'b0;
    bp.ex_taken = 1'b0;
    bp.ex_ghr = '0;
    bp.ex_mispredict = 1'b0;
  endtask

  function automatic bit model_hit(input int pc);
    int bidx;
    bidx = pc % NENT;
    return m_v[bidx] && (m_tag[bidx] == pc / NENT);
  endfunction

  function automatic bit model_dir(input int pc);
    return m_pht[(pc % NENT) ^ m_ghr] >= CINIT;
  endfunction

  // Compare every observable output with the model, mid-cycle.
  task automatic sample();
    int pc, bidx, exp_pc;
    bit tk;
    @(negedge clk);
    pc = int'(bp.pc);
    bidx = pc % NENT;
    tk = model_hit(pc) && (m_j[bidx] || model_dir(pc));
    exp_pc = tk ? m_tgt[bidx] : int'(bp.pc_next_seq);
    chk("new_pc", bp.new_pc, exp_pc);
    chk("pred_taken", bp.pred_taken, tk);
    chk("pred_ghr", bp.pred_ghr, m_ghr);
`ifdef BP_STATS_EN
    chk("stat_lookups", stat_lookups, m_st_look);
    chk("stat_branches", stat_branches, m_st_br);
    chk("stat_mispredicts", stat_mispredicts, m_st_mis);
`endif
  endtask

  task automatic model_update();
    int pc, bidx, p, ng;
    if (!reset_n) begin
      for (int i = 0; i < NENT; i++) begin
        m_v[i] = 0; m_j[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_pht[i] = CINIT;
      end
      m_ghr = 0;
      m_st_look = 0; m_st_br = 0; m_st_mis = 0;
    end else begin
      pc = int'(bp.pc);
      bidx = pc % NENT;
      ng = m_ghr;
      if (bp.ex_valid && bp.ex_mispredict)
        ng = bp.ex_is_branch ? ((int'(bp.ex_ghr) * 2 + int'(bp.ex_taken)) % (1 << GB))
                             : int'(bp.ex_ghr);
      else if (bp.fetch_valid && model_hit(pc) && !m_j[bidx])
        ng = (m_ghr * 2 + int'(model_dir(pc))) % (1 << GB);
      if (bp.fetch_valid && model_hit(pc)) m_st_look++;
      if (bp.ex_valid && bp.ex_is_branch) m_st_br++;
      if (bp.ex_valid && bp.ex_mispredict) m_st_mis++;
      if (bp.ex_valid && bp.ex_is_branch) begin
        p = (int'(bp.ex_pc) % NENT) ^ int'(bp.ex_ghr);
        if (bp.ex_taken && m_pht[p] < CMAX) m_pht[p]++;
        else if (!bp.ex_taken && m_pht[p] > 0) m_pht[p]--;
      end
      if (bp.id_update) begin
        p = int'(bp.id_pc) % NENT;
        m_v[p] = 1;
        m_j[p] = bp.id_is_jump;
        m_tag[p] = int'(bp.id_pc) / NENT;
        m_tgt[p] = int'(bp.id_target);
      end
      m_ghr = ng;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 1'b0;
    advance();
    advance();
    reset_n = 1'b1;
  endtask

  initial begin
    set_idle();
    bp.pc = '0;
    bp.pc_next_seq = '0;
    do_reset();

    // Reset state
    bp.pc = 16'h0010; bp.pc_next_seq = 16'h0011;
    sample();
    chk("rst_new_pc", bp.new_pc, 16'h0011);
    chk("rst_pred_taken", bp.pred_taken, 0);
    chk("rst_pred_ghr", bp.pred_ghr, 0);
    advance();

    // Unconditional jump 0x0010 -> 0x0040
    bp.id_update = 1'b1; bp.id_pc = 16'h0010; bp.id_target = 16'h0040; bp.id_is_jump = 1'b1;
    step();
    set_idle();
    bp.fetch_valid = 1'b1;
    sample();
    chk("jmp_new_pc", bp.new_pc, 16'h0040);
    chk("jmp_pred_taken", bp.pred_taken, 1);
    advance();
    bp.fetch_valid = 1'b0;
    sample();
    chk("jmp_ghr_hold", bp.pred_ghr, 0);
    advance();

    // Conditional branch 0x0020 -> 0x0005
    bp.id_update = 1'b1; bp.id_pc = 16'h0020; bp.id_target = 16'h0005; bp.id_is_jump = 1'b0;
    step();
    set_idle();
    bp.pc = 16'h0020; bp.pc_next_seq = 16'h0021; bp.fetch_valid = 1'b1;
    sample();
    chk("br_new_pc", bp.new_pc, 16'h0005);
    chk("br_pred_taken", bp.pred_taken, 1);
    advance();
    bp.fetch_valid = 1'b0;
    sample();
    chk("br_ghr_shift", bp.pred_ghr, 8'h01);
    advance();
    bp.ex_valid = 1'b1; bp.ex_is_branch = 1'b1; bp.ex_pc = 16'h0020; bp.ex_ghr = 8'h00; bp.ex_taken = 1'b0;
    step();
    step();
    // Non-branch repair restores GHR=0 without touching the PHT
    bp.ex_is_branch = 1'b0; bp.ex_mispredict = 1'b1; bp.ex_ghr = 8'h00;
    step();
    set_idle();
    bp.fetch_valid = 1'b1;
    sample();
    chk("br_nt_new_pc", bp.new_pc, 16'h0021);
    chk("br_nt_pred_taken", bp.pred_taken, 0);
    advance();

    // Repair beats a same-cycle speculative shift
    set_idle();
    bp.ex_valid = 1'b1; bp.ex_mispredict = 1'b1; bp.ex_ghr = 8'h0B;
    step();
    sample();
    chk("ghr_0b", bp.pred_ghr, 8'h0B);
    bp.ex_is_branch = 1'b1; bp.ex_ghr = 8'h05; bp.ex_taken = 1'b0; bp.ex_pc = 16'h0020;
    bp.fetch_valid = 1'b1; bp.pc = 16'h0020;
    advance();
    set_idle();
    sample();
    chk("repair_ghr", bp.pred_ghr, 8'h0A);
    advance();

    // Tag alias misses
    bp.pc = 16'h0110; bp.pc_next_seq = 16'h0111;
    sample();
    chk("alias_new_pc", bp.new_pc, 16'h0111);
    chk("alias_pred_taken", bp.pred_taken, 0);
    advance();

    // Randomised traffic over a small address pool so entries collide
    for (int n = 0; n < 2000; n++) begin
      bp.pc = WS'($urandom_range(0, 1) * 256 + $urandom_range(0, 15));
      bp.pc_next_seq = bp.pc + 16'd1;
      bp.fetch_valid = $urandom_range(0, 3) != 0;
      bp.id_update = $urandom_range(0, 3) == 0;
      bp.id_pc = WS'($urandom_range(0, 1) * 256 + $urandom_range(0, 15));
      bp.id_target = WS'($urandom);
      bp.id_is_jump = $urandom_range(0, 2) == 0;
      bp.ex_valid = $urandom_range(0, 1) != 0;
      bp.ex_pc = WS'($urandom_range(0, 1) * 256 + $urandom_range(0, 15));
      bp.ex_is_branch = $urandom_range(0, 3) != 0;
      bp.ex_taken = $urandom_range(0, 1) != 0;
      bp.ex_ghr = GB'($urandom_range(0, 31));
      bp.ex_mispredict = $urandom_range(0, 7) == 0;
      reset_n = $urandom_range(0, 299) != 0;
      step();
    end
    reset_n = 1'b1;

`ifdef BP_STATS_EN
    do_reset();
    bp.id_update = 1'b1; bp.id_pc = 16'h0030; bp.id_target = 16'h0100; bp.id_is_jump = 1'b1;
    step();
    set_idle();
    bp.pc = 16'h0030; bp.pc_next_seq = 16'h0031; bp.fetch_valid = 1'b1;
    step(); step(); step();
    set_idle();
    bp.ex_valid = 1'b1; bp.ex_is_branch = 1'b1; bp.ex_pc = 16'h0030;
    step();
    bp.ex_mispredict = 1'b1; bp.ex_taken = 1'b1;
    step();
    set_idle();
    sample();
    chk("stat_look_3", stat_lookups, 3);
    chk("stat_br_2", stat_branches, 2);
    chk("stat_mis_1", stat_mispredicts, 1);
    advance();
    do_reset();
    sample();
    chk("stat_look_rst", stat_lookups, 0);
    chk("stat_br_rst", stat_branches, 0);
    chk("stat_mis_rst", stat_mispredicts, 0);
    advance();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
